// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M multiply/divide sequencer.
// Contents: FSM state enum, the eight M-extension Funct3 codes, and the
// predicates that pick divide vs multiply and operand signedness.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Divide/remainder ops all have Funct3[2] set.
    function automatic logic is_div(input logic [2:0] f);
        return f[2];
    endfunction

    // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM.
    function automatic logic is_signed_a(input logic [2:0] f);
        return (f == F3_MUL) || (f == F3_MULH) || (f == F3_MULHSU) ||
               (f == F3_DIV) || (f == F3_REM);
    endfunction

    // rs2 is treated as signed for MUL, MULH, DIV and REM.
    function automatic logic is_signed_b(input logic [2:0] f);
        return (f == F3_MUL) || (f == F3_MULH) ||
               (f == F3_DIV) || (f == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer.
// Captures operands on start, runs WIDTH radix-2 iterations (shift-add
// multiply or restoring divide) on magnitudes, then applies sign fix-up and
// divide-by-zero override on the edge leaving CALC.
// Ports:
//   clk, reset        - rising-edge clock, async active-high reset
//   start, Funct3     - request and M-extension op code (sampled in IDLE/DONE)
//   SrcA, SrcB        - rs1 / rs2 operand values
//   flush             - synchronous abort back to IDLE, Result untouched
//   busy              - high while iterating (CALC)
//   done              - one-cycle pulse when Result is valid
//   Result            - registered result, held until the next accepted op
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result
);

    localparam int unsigned W2 = 2 * WIDTH;

    state_t             state_q,    state_d;
    logic [WIDTH-1:0]   count_q,    count_d;
    logic [2:0]         op_q,       op_d;
    logic               sign_a_q,   sign_a_d;
    logic               sign_b_q,   sign_b_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   raw_a_q,    raw_a_d;
    logic [WIDTH-1:0]   opnd_q,     opnd_d;     // |multiplicand| or |divisor|
    logic [WIDTH-1:0]   acc_hi_q,   acc_hi_d;   // product high / partial remainder
    logic [WIDTH-1:0]   acc_lo_q,   acc_lo_d;   // multiplier / dividend -> quotient
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic [WIDTH-1:0]   result_q,   result_d;

    logic               sa, sb;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [W2-1:0]      prod;
    logic [W2-1:0]      prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Next-state, operand capture, iteration step and final fix-up.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_d       = op_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        div_zero_d = div_zero_q;
        raw_a_d    = raw_a_q;
        opnd_d     = opnd_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        result_d   = result_q;

        sa    = is_signed_a(Funct3) & SrcA[WIDTH-1];
        sb    = is_signed_b(Funct3) & SrcB[WIDTH-1];
        abs_a = sa ? (~SrcA + WIDTH'(1)) : SrcA;
        abs_b = sb ? (~SrcB + WIDTH'(1)) : SrcB;

        // Multiply step: conditional add then shift the whole accumulator right.
        mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        // Restoring divide step: shift in next dividend bit, trial subtract.
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};

        prod     = '0;
        prod_fix = '0;
        quo_fix  = '0;
        rem_fix  = '0;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d    = CALC;
                        count_d    = '0;
                        op_d       = Funct3;
                        sign_a_d   = sa;
                        sign_b_d   = sb;
                        div_zero_d = (SrcB == '0);
                        raw_a_d    = SrcA;
                        acc_hi_d   = '0;
                        opnd_d     = is_div(Funct3) ? abs_b : abs_a;
                        acc_lo_d   = is_div(Funct3) ? abs_a : abs_b;
                    end else begin
                        state_d = IDLE;
                    end
                end
                CALC: begin
                    count_d = count_q + WIDTH'(1);
                    if (is_div(op_q)) begin
                        acc_hi_d = div_trial[WIDTH] ? div_shift[WIDTH-1:0]
                                                    : div_trial[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
                    end else begin
                        acc_hi_d = mul_sum[WIDTH:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                    end

                    // Last iteration: sign fix-up and zero-divisor override.
                    prod     = {acc_hi_d, acc_lo_d};
                    prod_fix = (sign_a_q ^ sign_b_q) ? (~prod + W2'(1)) : prod;
                    quo_fix  = (sign_a_q ^ sign_b_q) ? (~acc_lo_d + WIDTH'(1)) : acc_lo_d;
                    rem_fix  = sign_a_q ? (~acc_hi_d + WIDTH'(1)) : acc_hi_d;
                    if (div_zero_q) begin
                        quo_fix = '1;
                        rem_fix = raw_a_q;
                    end

                    if (count_q == WIDTH'(WIDTH - 1)) begin
                        state_d = DONE;
                        if (is_div(op_q)) begin
                            result_d = op_q[1] ? rem_fix : quo_fix;
                        end else begin
                            result_d = (op_q == F3_MUL) ? prod_fix[WIDTH-1:0]
                                                        : prod_fix[W2-1:WIDTH];
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == CALC);
        done_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            op_q       <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            raw_a_q    <= '0;
            opnd_q     <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_q       <= op_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            div_zero_q <= div_zero_d;
            raw_a_q    <= raw_a_d;
            opnd_q     <= opnd_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign Result = result_q;

endmodule
